// File: rtl/wfg_stim_mem.sv
// wfg_stim_mem: memory-backed stimulus source for the SPI drive stage.
// Walks an address window of a synchronous single-port SRAM, scales each
// word by an unsigned 8.8 gain and presents the result as an AXI-Stream master.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   ctrl_en_q_i              stimulus enable (deassert = abort)
//   cfg_start_q_i/end/inc    address window (end inclusive, inc 0 acts as 1)
//   gain_val_q_i             unsigned 8.8 gain, 0x0100 = unity
//   mem_csb_o/addr_o/dout_i  SRAM read port (data one cycle after csb low)
//   wfg_stim_mem_t*          AXI-Stream master (tvalid/tready/tdata/tlast)
module wfg_stim_mem #(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned MEM_ADDR_WIDTH  = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       ctrl_en_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_start_q_i,
  input  logic [MEM_ADDR_WIDTH-1:0]  cfg_end_q_i,
  input  logic [7:0]                 cfg_inc_q_i,
  input  logic [15:0]                gain_val_q_i,
  output logic                       mem_csb_o,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [AXIS_DATA_WIDTH-1:0] mem_dout_i,
  output logic                       wfg_stim_mem_tvalid_o,
  input  logic                       wfg_stim_mem_tready_i,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_stim_mem_tdata_o,
  output logic                       wfg_stim_mem_tlast_o
);

  localparam int unsigned DW = AXIS_DATA_WIDTH;
  localparam int unsigned AW = MEM_ADDR_WIDTH;

  logic          en_q;
  logic [AW-1:0] ptr;
  logic          rd_vld;
  logic          rd_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_idx;
  logic          rd_idx;
  logic [1:0]    count;

  logic          rise;
  logic          pop;
  logic [2:0]    occ_net;
  logic          issue;
  logic [7:0]    inc_eff;
  logic [AW:0]   next_sum;
  logic          wrap;
  logic [DW+15:0] product;
  logic [DW-1:0] scaled;
  logic          unused_product;

  assign rise = ctrl_en_q_i & ~en_q;
  assign pop  = (count != 2'd0) & wfg_stim_mem_tready_i;

  // Credit includes the beat leaving this cycle so a steady tready sustains
  // one beat per cycle while buffered + in-flight never exceeds two.
  assign occ_net = {1'b0, count} + {2'b0, rd_vld} - {2'b0, pop};
  assign issue   = !wb_rst_i && ctrl_en_q_i && en_q && (occ_net < 3'd2);

  assign inc_eff  = (cfg_inc_q_i == 8'd0) ? 8'd1 : cfg_inc_q_i;
  assign next_sum = {1'b0, ptr} + {{(AW-7){1'b0}}, inc_eff};
  // ptr >= end also covers a degenerate window (start > end): stay at start.
  assign wrap     = (ptr >= cfg_end_q_i) || (next_sum > {1'b0, cfg_end_q_i});

  assign product = {16'b0, mem_dout_i} * {{DW{1'b0}}, gain_val_q_i};
  assign scaled  = product[DW+7:8];
  assign unused_product = ^{product[DW+15:DW+8], product[7:0]};

  assign mem_csb_o  = ~issue;
  assign mem_addr_o = issue ? ptr : '0;

  assign wfg_stim_mem_tvalid_o = (count != 2'd0);
  assign wfg_stim_mem_tdata_o  = fifo_data[rd_idx];
  assign wfg_stim_mem_tlast_o  = fifo_last[rd_idx];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en_q         <= 1'b0;
      ptr          <= '0;
      rd_vld       <= 1'b0;
      rd_last      <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= 2'b00;
      wr_idx       <= 1'b0;
      rd_idx       <= 1'b0;
      count        <= 2'd0;
    end else begin
      en_q <= ctrl_en_q_i;
      if (!ctrl_en_q_i) begin
        // Abort: drop buffered beats and any read still in flight.
        rd_vld  <= 1'b0;
        rd_last <= 1'b0;
        wr_idx  <= 1'b0;
        rd_idx  <= 1'b0;
        count   <= 2'd0;
      end else begin
        if (rise) begin
          ptr <= cfg_start_q_i;
        end else if (issue) begin
          ptr <= wrap ? cfg_start_q_i : next_sum[AW-1:0];
        end
        rd_vld  <= issue;
        rd_last <= issue & wrap;
        if (rd_vld) begin
          fifo_data[wr_idx] <= scaled;
          fifo_last[wr_idx] <= rd_last;
          wr_idx            <= ~wr_idx;
        end
        if (pop) begin
          rd_idx <= ~rd_idx;
        end
        count <= count + {1'b0, rd_vld} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_wfg_stim_mem.sv
module tb_wfg_stim_mem;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_en = 1'b0;
  logic [15:0] cfg_start = '0;
  logic [15:0] cfg_end = '0;
  logic [7:0]  cfg_inc = 8'd1;
  logic [15:0] gain = 16'h0100;
  logic        mem_csb;
  logic [15:0] mem_addr;
  logic [31:0] mem_dout = '0;
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic        tlast;

  logic [31:0] mem [0:255];
  beat_t       exp_q[$];

  int  n_checks = 0;
  int  n_pass = 0;
  bit  rand_bp = 0;
  bit  hold_rdy = 0;
  bit  free_run = 0;

  wfg_stim_mem dut (
    .wb_clk_i              (clk),
    .wb_rst_i              (rst),
    .ctrl_en_q_i           (ctrl_en),
    .cfg_start_q_i         (cfg_start),
    .cfg_end_q_i           (cfg_end),
    .cfg_inc_q_i           (cfg_inc),
    .gain_val_q_i          (gain),
    .mem_csb_o             (mem_csb),
    .mem_addr_o            (mem_addr),
    .mem_dout_i            (mem_dout),
    .wfg_stim_mem_tvalid_o (tvalid),
    .wfg_stim_mem_tready_i (tready),
    .wfg_stim_mem_tdata_o  (tdata),
    .wfg_stim_mem_tlast_o  (tlast)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read
  always @(posedge clk) begin
    if (!mem_csb) mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drives tready, pops the scoreboard on each handshake,
  // and checks tdata stays put while stalled.
  initial begin : monitor
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      tready = (exp_q.size() != 0 || free_run) && !hold_rdy &&
               (!rand_bp || $urandom_range(0, 3) != 0);
      if (!rst) begin
        if (prev_stall && ctrl_en) begin
          chk("stall_tvalid", tvalid, 1);
          chk("stall_tdata", tdata, prev_data);
          chk("stall_tlast", tlast, prev_last);
        end
        if (tvalid && tready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_tdata", tdata, e.d);
          chk("beat_tlast", tlast, e.l);
        end
        prev_stall = tvalid && !tready && ctrl_en;
        prev_data  = tdata;
        prev_last  = tlast;
      end else begin
        prev_stall = 0;
      end
    end
  end

  // Outstanding-credit tracker: reads issued minus beats accepted.
  initial begin : credit_mon
    int outst = 0;
    forever begin
      @(posedge clk);
      if (rst || !ctrl_en) begin
        outst = 0;
      end else begin
        outst = outst + (mem_csb ? 0 : 1) - ((tvalid && tready) ? 1 : 0);
        if (outst > 2 || outst < 0) chk("outstanding_le2", outst, 2);
      end
    end
  end

  // Reference: the window is the arithmetic list start, start+inc, ... <= end
  // (just start when start > end); the stream cycles through it, tlast on the
  // final element; each word is scaled as floor(word*gain/256) mod 2^32.
  task automatic run_window(input int s, input int e, input int inc, input int g,
                            input int nbeats, input bit bp, input bit stall5,
                            input bit chk_lat);
    int    w[$];
    int    ie;
    int    cyc;
    int    idx;
    longint prod;
    beat_t b;
    ie = (inc == 0) ? 1 : inc;
    if (s > e) w.push_back(s);
    else for (int a = s; a <= e; a += ie) w.push_back(a);
    for (int k = 0; k < nbeats; k++) begin
      idx  = k % w.size();
      prod = (longint'(mem[w[idx]]) * longint'(g)) >>> 8;
      b.d  = prod[31:0];
      b.l  = (idx == w.size() - 1);
      exp_q.push_back(b);
    end
    cfg_start = 16'(s);
    cfg_end   = 16'(e);
    cfg_inc   = 8'(inc);
    gain      = 16'(g);
    rand_bp   = bp;
    step();
    ctrl_en = 1'b1;
    if (chk_lat) begin
      step();
      step();
      chk("latency_not_yet", tvalid, 0);
      step();
      chk("latency_first", tvalid, 1);
    end
    if (stall5) begin
      repeat (6) step();
      hold_rdy = 1;
      repeat (5) step();
      hold_rdy = 0;
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      step();
      cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    ctrl_en = 1'b0;
    rand_bp = 0;
    step();
    step();
  endtask

  initial begin
    int found;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i + 10);
    mem[100] = 32'h0000_1234;
    mem[101] = 32'hFFFF_FFFF;

    repeat (2) step();
    chk("rst_csb", mem_csb, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    rst = 0;
    step();

    run_window(0, 3, 1, 16'h0100, 10, 0, 0, 1);   // basic window + latency
    run_window(0, 3, 1, 16'h0100, 16, 0, 1, 0);   // 5-cycle stall
    run_window(0, 3, 1, 16'h0100, 20, 1, 0, 0);   // random backpressure
    run_window(0, 4, 2, 16'h0100, 7, 0, 0, 0);    // 0,2,4
    run_window(0, 4, 3, 16'h0100, 5, 0, 0, 0);    // 0,3
    run_window(0, 3, 0, 16'h0100, 6, 0, 0, 0);    // inc 0 as 1
    run_window(100, 100, 1, 16'h0200, 3, 0, 0, 0);
    run_window(100, 100, 1, 16'h0080, 3, 0, 0, 0);
    run_window(101, 101, 1, 16'h0200, 3, 0, 0, 0);
    run_window(5, 2, 1, 16'h0100, 4, 0, 0, 0);    // degenerate window

    // Abort with both FIFO entries full
    cfg_start = 16'd0; cfg_end = 16'd3; cfg_inc = 8'd1; gain = 16'h0100;
    hold_rdy = 1;
    ctrl_en = 1'b1;
    repeat (6) step();
    chk("abort_full_tvalid", tvalid, 1);
    chk("abort_full_tdata", tdata, 10);
    ctrl_en = 1'b0;
    step();
    chk("abort_tvalid", tvalid, 0);
    chk("abort_csb", mem_csb, 1);
    step();
    hold_rdy = 0;
    run_window(0, 3, 1, 16'h0100, 6, 0, 0, 0);    // restart from start

    for (int r = 0; r < 8; r++) begin
      run_window($urandom_range(0, 40), $urandom_range(0, 60), $urandom_range(0, 6),
                 $urandom_range(0, 16'hFFFF), $urandom_range(10, 30), 1, 0, 0);
    end

    // Reset mid-read
    free_run = 1;
    cfg_start = 16'd0; cfg_end = 16'd3; cfg_inc = 8'd1; gain = 16'h0100;
    ctrl_en = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (!mem_csb && tvalid) found = 1;
    end
    chk("rst_mid_read_seen", found, 1);
    rst = 1'b1;
    ctrl_en = 1'b0;
    #1;
    chk("rst_async_csb", mem_csb, 1);
    chk("rst_async_addr", mem_addr, 0);
    chk("rst_async_tvalid", tvalid, 0);
    chk("rst_async_tdata", tdata, 0);
    chk("rst_async_tlast", tlast, 0);
    free_run = 0;
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
